// File: rtl/adder_nibble_sched.sv
// Wide adder sequencer: time-shares an external 4-bit adder slice, one nibble per cycle LSB first,
// with round-robin arbitration between two requesters and a valid/ready response channel.
module adder_nibble_sched #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [4*NIBBLES-1:0]   req0_a,
   input  logic [4*NIBBLES-1:0]   req0_b,
   input  logic                   req0_cin,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [4*NIBBLES-1:0]   req1_a,
   input  logic [4*NIBBLES-1:0]   req1_b,
   input  logic                   req1_cin,
   output logic [3:0]             slc_a,
   output logic [3:0]             slc_b,
   output logic                   slc_cin,
   input  logic [3:0]             slc_sum,
   input  logic                   slc_cout,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [4*NIBBLES-1:0]   resp_sum,
   output logic                   resp_cout,
   output logic                   resp_id
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IdxW = $clog2(NIBBLES);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic              rr_q, rr_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              carry_q, carry_d;
   logic              id_q, id_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              grant0, grant1;
   logic [IdxW+1:0]   bit_ofs;

   // rr_q == 0 favours requester 0 on a tie; it always points away from the last one served.
   assign grant0  = req0_valid & (~req1_valid | ~rr_q);
   assign grant1  = req1_valid & (~req0_valid | rr_q);
   assign bit_ofs = {idx_q, 2'b00};

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      carry_d    = carry_q;
      id_d       = id_q;
      idx_d      = idx_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      slc_a      = 4'h0;
      slc_b      = 4'h0;
      slc_cin    = 1'b0;
      resp_valid = 1'b0;
      resp_sum   = '0;
      resp_cout  = 1'b0;
      resp_id    = 1'b0;

      unique case (state_q)
         StIdle: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0 || grant1) begin
               a_d     = grant1 ? req1_a : req0_a;
               b_d     = grant1 ? req1_b : req0_b;
               carry_d = grant1 ? req1_cin : req0_cin;
               id_d    = grant1;
               rr_d    = grant0;
               idx_d   = '0;
               sum_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            slc_a                 = a_q[bit_ofs +: 4];
            slc_b                 = b_q[bit_ofs +: 4];
            slc_cin               = carry_q;
            // Slice results are stored untouched so approximate slices show through.
            sum_d[bit_ofs +: 4]   = slc_sum;
            carry_d               = slc_cout;
            idx_d                 = idx_q + IdxW'(1);
            if (idx_q == IdxW'(NIBBLES - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            resp_valid = 1'b1;
            resp_sum   = sum_q;
            resp_cout  = carry_q;
            resp_id    = id_q;
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rr_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         id_q    <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         id_q    <= id_d;
         idx_q   <= idx_d;
      end
   end

   ready_onehot: assert property (@(posedge clk) disable iff (rst)
      !(req0_ready && req1_ready));

   ready_idle_only: assert property (@(posedge clk) disable iff (rst)
      (req0_ready || req1_ready) |-> (state_q == StIdle));

   resp_hold: assert property (@(posedge clk) disable iff (rst)
      (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_sum) && $stable(resp_cout)
                                       && $stable(resp_id)));

endmodule

// File: tb/tb_adder_nibble_sched.sv
// Bench for adder_nibble_sched: behavioural slice, cycle-level reference model and response
// scoreboard run as a monitor, plus one task per scenario.
module tb_adder_nibble_sched;
   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   typedef struct packed {
      logic         id;
      logic         cout;
      logic [W-1:0] sum;
   } resp_t;

   logic clk = 1'b0;
   logic rst;
   logic req0_valid, req0_ready, req0_cin;
   logic req1_valid, req1_ready, req1_cin;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0] slc_a, slc_b, slc_sum;
   logic slc_cin, slc_cout;
   logic resp_valid, resp_ready, resp_cout, resp_id;
   logic [W-1:0] resp_sum;
   logic stuck;
   logic [4:0] slc_t;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Reference model state, updated at each negedge for the following posedge.
   int phase = 0;
   int cnt = 0;
   logic rr = 1'b0;
   logic mc = 1'b0;
   logic [W-1:0] cur_a = '0;
   logic [W-1:0] cur_b = '0;
   int n_acc = 0;
   int n_resp = 0;
   int acc_cyc = 0;
   int latency = 0;
   int hs_cyc = 0;
   resp_t exp_q[$];
   resp_t resp_log[$];
   int acc_id_log[$];
   int acc_cyc_log[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slice: exact adder, optionally with sum bit 0 stuck at 0.
   always_comb begin
      slc_t   = {1'b0, slc_a} + {1'b0, slc_b} + {4'b0, slc_cin};
      slc_sum = slc_t[3:0];
      if (stuck) slc_sum[0] = 1'b0;
      slc_cout = slc_t[4];
   end

   adder_nibble_sched #(.NIBBLES(NIB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .slc_a      (slc_a),
      .slc_b      (slc_b),
      .slc_cin    (slc_cin),
      .slc_sum    (slc_sum),
      .slc_cout   (slc_cout),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .resp_id    (resp_id)
   );

   function automatic resp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic stk);
      resp_t r;
      logic c;
      logic [4:0] t;
      c = cin;
      r = '0;
      for (int i = 0; i < NIB; i++) begin
         t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
         if (stk) t[0] = 1'b0;
         r.sum[4*i +: 4] = t[3:0];
         c = t[4];
      end
      r.cout = c;
      r.id   = id;
      return r;
   endfunction

   task automatic monitor();
      logic g0, g1;
      logic [8:0] exp_slc;
      logic [4:0] t;
      resp_t e;
      forever begin
         @(negedge clk);
         g0 = req0_valid & (!req1_valid | !rr);
         g1 = req1_valid & (!req0_valid | rr);
         if (phase != 0) begin
            g0 = 1'b0;
            g1 = 1'b0;
         end
         total++;
         if ({req0_ready, req1_ready} !== {g0, g1}) begin
            bad++;
            $display("FAIL ready cyc=%0d: got %b%b want %b%b", cyc, req0_ready, req1_ready, g0, g1);
         end
         exp_slc = '0;
         if (phase == 1) exp_slc = {cur_a[4*cnt +: 4], cur_b[4*cnt +: 4], mc};
         total++;
         if ({slc_a, slc_b, slc_cin} !== exp_slc) begin
            bad++;
            $display("FAIL slice drive cyc=%0d: got %h want %h", cyc, {slc_a, slc_b, slc_cin}, exp_slc);
         end
         total++;
         if (phase == 2) begin
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL resp cyc=%0d: got valid=%b with empty scoreboard", cyc, resp_valid);
            end else begin
               e = exp_q[0];
               if ({resp_valid, resp_id, resp_cout, resp_sum} !== {1'b1, e}) begin
                  bad++;
                  $display("FAIL resp cyc=%0d: got v=%b id=%b c=%b s=%h want v=1 id=%b c=%b s=%h",
                           cyc, resp_valid, resp_id, resp_cout, resp_sum, e.id, e.cout, e.sum);
               end
            end
         end else if ({resp_valid, resp_id, resp_cout, resp_sum} !== '0) begin
            bad++;
            $display("FAIL resp idle cyc=%0d: got v=%b id=%b c=%b s=%h want all 0",
                     cyc, resp_valid, resp_id, resp_cout, resp_sum);
         end
         if (rst) begin
            phase = 0;
            rr    = 1'b0;
            exp_q.delete();
         end else begin
            case (phase)
               0: if (g0 || g1) begin
                  cur_a = g1 ? req1_a : req0_a;
                  cur_b = g1 ? req1_b : req0_b;
                  mc    = g1 ? req1_cin : req0_cin;
                  exp_q.push_back(model(g1, cur_a, cur_b, mc, stuck));
                  acc_id_log.push_back(g1 ? 1 : 0);
                  acc_cyc_log.push_back(cyc + 1);
                  acc_cyc = cyc + 1;
                  rr      = g0;
                  cnt     = 0;
                  phase   = 1;
                  n_acc++;
               end
               1: begin
                  t  = {1'b0, cur_a[4*cnt +: 4]} + {1'b0, cur_b[4*cnt +: 4]} + {4'b0, mc};
                  mc = t[4];
                  if (cnt == NIB - 1) begin
                     phase   = 2;
                     latency = cyc + 1 - acc_cyc;
                  end else begin
                     cnt++;
                  end
               end
               2: if (resp_ready) begin
                  resp_log.push_back({resp_id, resp_cout, resp_sum});
                  void'(exp_q.pop_front());
                  hs_cyc = cyc + 1;
                  phase  = 0;
                  n_resp++;
               end
               default: phase = 0;
            endcase
         end
      end
   endtask

   task automatic wait_acc(input int target, output bit ok);
      for (int i = 0; i < 100 && n_acc < target; i++) begin
         @(posedge clk);
         #1;
      end
      ok = (n_acc >= target);
   endtask

   task automatic wait_resp(input int target, output bit ok);
      for (int i = 0; i < 100 && n_resp < target; i++) begin
         @(posedge clk);
         #1;
      end
      ok = (n_resp >= target);
   endtask

   task automatic run_one(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, output bit ok);
      int na, nr;
      na = n_acc;
      nr = n_resp;
      if (id) begin
         req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
      end
      wait_acc(na + 1, ok);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (ok) wait_resp(nr + 1, ok);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      {req0_valid, req0_cin, req1_valid, req1_cin} = '0;
      {req0_a, req0_b, req1_a, req1_b} = '0;
      resp_ready = 1'b0;
      stuck = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         bad++; $display("FAIL reset ready: got %b%b want 00", req0_ready, req1_ready);
      end
      total++;
      if (resp_valid !== 1'b0) begin
         bad++; $display("FAIL reset resp_valid: got %b want 0", resp_valid);
      end
      total++;
      if ({resp_sum, resp_cout, resp_id} !== '0) begin
         bad++; $display("FAIL reset resp data: got %h/%b/%b want 0", resp_sum, resp_cout, resp_id);
      end
      total++;
      if ({slc_a, slc_b, slc_cin} !== 9'h0) begin
         bad++; $display("FAIL reset slice: got %h want 0", {slc_a, slc_b, slc_cin});
      end
   endtask

   task automatic test_basic();
      bit ok;
      resp_ready = 1'b1;
      run_one(1'b0, 16'h1234, 16'h0FCD, 1'b0, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL basic timeout: got no response want one");
      end else begin
         total++;
         if (resp_log[resp_log.size()-1] !== {1'b0, 1'b0, 16'h2201}) begin
            bad++; $display("FAIL basic result: got %h want %h", resp_log[resp_log.size()-1],
                            {1'b0, 1'b0, 16'h2201});
         end
         // First DONE cycle comes NIB edges after the accept edge.
         total++;
         if (latency != NIB) begin
            bad++; $display("FAIL basic latency: got %0d want %0d", latency, NIB);
         end
      end
   endtask

   task automatic test_carry();
      bit ok;
      resp_ready = 1'b1;
      run_one(1'b1, 16'hFFFF, 16'h0001, 1'b0, ok);
      total++;
      if (!ok || resp_log[resp_log.size()-1] !== {1'b1, 1'b1, 16'h0000}) begin
         bad++; $display("FAIL carry wrap: got ok=%b %h want %h", ok, resp_log[resp_log.size()-1],
                         {1'b1, 1'b1, 16'h0000});
      end
      run_one(1'b1, 16'hFFFF, 16'h0000, 1'b1, ok);
      total++;
      if (!ok || resp_log[resp_log.size()-1] !== {1'b1, 1'b1, 16'h0000}) begin
         bad++; $display("FAIL carry cin: got ok=%b %h want %h", ok, resp_log[resp_log.size()-1],
                         {1'b1, 1'b1, 16'h0000});
      end
   endtask

   task automatic test_contention();
      bit ok;
      int base, na, nr;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      resp_ready = 1'b1;
      base = acc_id_log.size();
      na = n_acc;
      nr = n_resp;
      req0_a = 16'h0102; req0_b = 16'h0304; req0_cin = 1'b0; req0_valid = 1'b1;
      req1_a = 16'hA0B0; req1_b = 16'h0C0D; req1_cin = 1'b1; req1_valid = 1'b1;
      wait_acc(na + 4, ok);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (ok) wait_resp(nr + 4, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL contention timeout: got acc=%0d resp=%0d want 4 each",
                         n_acc - na, n_resp - nr);
      end else begin
         for (int k = 0; k < 4; k++) begin
            total++;
            if (acc_id_log[base+k] != k % 2) begin
               bad++; $display("FAIL contention order %0d: got %0d want %0d", k,
                               acc_id_log[base+k], k % 2);
            end
         end
         for (int k = 1; k < 4; k++) begin
            total++;
            if (acc_cyc_log[base+k] - acc_cyc_log[base+k-1] != NIB + 2) begin
               bad++; $display("FAIL contention spacing %0d: got %0d want %0d", k,
                               acc_cyc_log[base+k] - acc_cyc_log[base+k-1], NIB + 2);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int na, nr;
      na = n_acc;
      nr = n_resp;
      resp_ready = 1'b0;
      req0_a = 16'h4321; req0_b = 16'h1234; req0_cin = 1'b1; req0_valid = 1'b1;
      wait_acc(na + 1, ok);
      req0_valid = 1'b0;
      req1_a = 16'h0001; req1_b = 16'h0002; req1_cin = 1'b0; req1_valid = 1'b1;
      for (int i = 0; i < 50 && phase != 2; i++) begin
         @(posedge clk);
         #1;
      end
      total++;
      if (!ok || phase != 2) begin
         bad++; $display("FAIL backpressure reach done: got phase=%0d want 2", phase);
      end
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      total++;
      if (resp_valid !== 1'b1 || n_acc != na + 1) begin
         bad++; $display("FAIL backpressure hold: got valid=%b acc=%0d want valid=1 acc=%0d",
                         resp_valid, n_acc, na + 1);
      end
      resp_ready = 1'b1;
      wait_resp(nr + 1, ok);
      if (ok) wait_acc(na + 2, ok);
      req1_valid = 1'b0;
      total++;
      if (!ok || acc_cyc_log[acc_cyc_log.size()-1] != hs_cyc + 1) begin
         bad++; $display("FAIL backpressure next accept: got edge %0d want %0d",
                         acc_cyc_log[acc_cyc_log.size()-1], hs_cyc + 1);
      end
      wait_resp(nr + 2, ok);
      total++;
      if (!ok || resp_log[resp_log.size()-2] !== {1'b0, 1'b0, 16'h5556}
              || resp_log[resp_log.size()-1] !== {1'b1, 1'b0, 16'h0003}) begin
         bad++; $display("FAIL backpressure results: got %h %h want %h %h",
                         resp_log[resp_log.size()-2], resp_log[resp_log.size()-1],
                         {1'b0, 1'b0, 16'h5556}, {1'b1, 1'b0, 16'h0003});
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int na, nr, base, rbase;
      resp_ready = 1'b1;
      na = n_acc;
      req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b0; req0_valid = 1'b1;
      wait_acc(na + 1, ok);
      req0_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      nr = n_resp;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if (!ok || resp_valid !== 1'b0 || {slc_a, slc_b, slc_cin} !== 9'h0) begin
         bad++; $display("FAIL reset mid-run: got ok=%b valid=%b slc=%h want 1/0/0", ok,
                         resp_valid, {slc_a, slc_b, slc_cin});
      end
      base  = acc_id_log.size();
      rbase = resp_log.size();
      na    = n_acc;
      req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
      req1_a = 16'h2222; req1_b = 16'h1111; req1_cin = 1'b0; req1_valid = 1'b1;
      wait_acc(na + 1, ok);
      req0_valid = 1'b0;
      if (ok) wait_acc(na + 2, ok);
      req1_valid = 1'b0;
      if (ok) wait_resp(nr + 2, ok);
      total++;
      if (!ok || n_resp != nr + 2) begin
         bad++; $display("FAIL reset mid-run responses: got %0d want 2", n_resp - nr);
      end else begin
         total++;
         if (acc_id_log[base] != 0 || acc_id_log[base+1] != 1) begin
            bad++; $display("FAIL reset mid-run grant: got %0d,%0d want 0,1", acc_id_log[base],
                            acc_id_log[base+1]);
         end
         total++;
         if (resp_log[rbase] !== {1'b0, 1'b0, 16'h0100}) begin
            bad++; $display("FAIL reset mid-run result: got %h want %h", resp_log[rbase],
                            {1'b0, 1'b0, 16'h0100});
         end
      end
   endtask

   task automatic test_approx();
      bit ok;
      resp_ready = 1'b1;
      stuck = 1'b1;
      run_one(1'b0, 16'h1111, 16'h0000, 1'b0, ok);
      total++;
      if (!ok || resp_log[resp_log.size()-1] !== {1'b0, 1'b0, 16'h0000}) begin
         bad++; $display("FAIL approx 1111: got ok=%b %h want %h", ok,
                         resp_log[resp_log.size()-1], {1'b0, 1'b0, 16'h0000});
      end
      run_one(1'b1, 16'h1234, 16'h1111, 1'b0, ok);
      total++;
      if (!ok || resp_log[resp_log.size()-1] !== {1'b1, 1'b0, 16'h2244}) begin
         bad++; $display("FAIL approx order: got ok=%b %h want %h", ok,
                         resp_log[resp_log.size()-1], {1'b1, 1'b0, 16'h2244});
      end
      stuck = 1'b0;
   endtask

   initial begin
      test_reset();
      fork
         monitor();
      join_none
      @(posedge clk);
      #1;
      rst = 1'b0;
      test_basic();
      test_carry();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_approx();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
